scfifo_wr_valid_model: RTL and testbench

- Write-side companion to the showahead single-clock FIFO valid-tracking model used in the taint/validity flow.
- Holds a shadow FIFO of 1-bit valid tags, one per stored word; exposes the head tag in showahead form to the read-side model.
- Tracks writes actually accepted (overflow checking on) and exports av/ai/assign tracking signals for the write port, plus registered copies.
- Sits beside the data scfifo; it is driven by the same wrreq/rdreq the data scfifo sees.

---
 rtl/scfifo_wr_valid_model.sv | 144 ++++++++++++++
 tb/tb_scfifo_wr_valid_model.sv | 131 +++++++++++++
 2 files changed

// File: rtl/scfifo_wr_valid_model.sv
// scfifo_wr_valid_model
// ---------------------------------------------------------------------------
// Write-side valid-tag shadow of a showahead single-clock FIFO. One 1-bit tag
// is stored per accepted word, and the head tag is shown combinationally on q.
// The block also exports registered write-port tracking signals (valid/av/ai/
// assign) and a further one-cycle-delayed copy of each.
//
// Ports
//   clock        single clock, all state on posedge
//   sclr         synchronous active-high clear, highest priority
//   valid_data   tag of the word being written
//   wrreq/rdreq  write request / showahead read acknowledge
//   q            head tag, 0 when empty
//   empty, full, almost_full, usedw   decodes of registered occupancy
//   overflow/underflow                one-cycle pulses for rejected requests
//   valid_w, av_w, ai_w, assign_w     write-port tracking signals
//   *_q                               the same tracking signals delayed a cycle
// ---------------------------------------------------------------------------
module scfifo_wr_valid_model #(
  parameter int lpm_numwords      = 16,
  parameter int lpm_widthu        = 4,
  parameter int almost_full_value = 12
) (
  input  logic                  clock,
  input  logic                  sclr,
  input  logic                  valid_data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic                  q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [lpm_widthu-1:0] usedw,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  valid_w,
  output logic                  av_w,
  output logic                  ai_w,
  output logic                  assign_w,
  output logic                  valid_w_q,
  output logic                  av_w_q,
  output logic                  ai_w_q,
  output logic                  assign_w_q
);

  localparam int CW = lpm_widthu + 1;
  localparam logic [CW-1:0]         NUMW     = CW'(lpm_numwords);
  localparam logic [CW-1:0]         AFV      = CW'(almost_full_value);
  localparam logic [lpm_widthu-1:0] LAST_PTR = lpm_widthu'(lpm_numwords - 1);

  // Tag storage; deliberately not cleared by sclr (q is gated by empty).
  logic mem_q [lpm_numwords];

  logic [lpm_widthu-1:0] rd_ptr_q, rd_ptr_d;
  logic [lpm_widthu-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  vw_q, vw_d;
  logic                  vw_dly_q, vw_dly_d;
  logic                  av_dly_q, av_dly_d;
  logic                  ai_dly_q, ai_dly_d;
  logic                  as_dly_q, as_dly_d;
  logic                  wr_ok, rd_ok;

  // Pointers wrap at the depth, which need not be a power of two.
  function automatic logic [lpm_widthu-1:0] ptr_inc(input logic [lpm_widthu-1:0] p);
    return (p == LAST_PTR) ? '0 : p + lpm_widthu'(1);
  endfunction

  // Flag decodes come from the registered occupancy only, so a same-cycle
  // read never makes room for a write while full.
  assign empty       = (occ_q == '0);
  assign full        = (occ_q == NUMW);
  assign almost_full = (occ_q >= AFV);
  assign usedw       = occ_q[lpm_widthu-1:0];
  assign q           = empty ? 1'b0 : mem_q[rd_ptr_q];

  assign wr_ok = wrreq & ~full;
  assign rd_ok = rdreq & ~empty;

  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign valid_w    = vw_q;
  assign av_w       = vw_q;
  assign ai_w       = ~vw_q;
  assign assign_w   = av_w | ai_w;
  assign valid_w_q  = vw_dly_q;
  assign av_w_q     = av_dly_q;
  assign ai_w_q     = ai_dly_q;
  assign assign_w_q = as_dly_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_ok, rd_ok})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    ovf_d    = wrreq & full;
    unf_d    = rdreq & empty;
    vw_d     = wr_ok & valid_data;
    vw_dly_d = valid_w;
    av_dly_d = av_w;
    ai_dly_d = ai_w;
    as_dly_d = assign_w;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      vw_q     <= 1'b0;
      vw_dly_q <= 1'b0;
      av_dly_q <= 1'b0;
      ai_dly_q <= 1'b0;
      as_dly_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      vw_q     <= vw_d;
      vw_dly_q <= vw_dly_d;
      av_dly_q <= av_dly_d;
      ai_dly_q <= ai_dly_d;
      as_dly_q <= as_dly_d;
    end
  end

  // A write during sclr is ignored, so the store is gated by sclr too.
  always_ff @(posedge clock) begin
    if (!sclr && wr_ok) mem_q[wr_ptr_q] <= valid_data;
  end

endmodule

// File: tb/tb_scfifo_wr_valid_model.sv
// Directed bench for scfifo_wr_valid_model (depth 4, usedw 2 bits, almost
// full at 3). A queue holds the tags the bench expects the FIFO to contain;
// it is pushed on accepted writes and popped on accepted reads, and every
// output is compared against that model after each clock edge.
module tb_scfifo_wr_valid_model;

  logic       clock = 1'b0;
  logic       sclr = 1'b0, valid_data = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
  logic       q_o, empty_o, full_o, afull_o, ovf_o, unf_o;
  logic [1:0] usedw_o;
  logic       vw_o, av_o, ai_o, as_o, vwq_o, avq_o, aiq_o, asq_o;

  int total = 0;
  int bad   = 0;

  // Bench model state
  bit tags[$];
  bit e_ovf = 0, e_unf = 0, e_vw = 0;
  bit e_vwq = 0, e_avq = 0, e_aiq = 0, e_asq = 0;

  always #5 clock = ~clock;

  scfifo_wr_valid_model #(
    .lpm_numwords(4), .lpm_widthu(2), .almost_full_value(3)
  ) dut (
    .clock(clock), .sclr(sclr), .valid_data(valid_data),
    .wrreq(wrreq), .rdreq(rdreq),
    .q(q_o), .empty(empty_o), .full(full_o), .almost_full(afull_o),
    .usedw(usedw_o), .overflow(ovf_o), .underflow(unf_o),
    .valid_w(vw_o), .av_w(av_o), .ai_w(ai_o), .assign_w(as_o),
    .valid_w_q(vwq_o), .av_w_q(avq_o), .ai_w_q(aiq_o), .assign_w_q(asq_o)
  );

  task automatic chk(input string name, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, take the edge, compare.
  task automatic cyc(input bit w, input bit r, input bit d, input bit s);
    bit fm, em, wok, rok;
    sclr = s; wrreq = w; rdreq = r; valid_data = d;
    if (s) begin
      tags.delete();
      e_ovf = 0; e_unf = 0; e_vw = 0;
      e_vwq = 0; e_avq = 0; e_aiq = 0; e_asq = 0;
    end else begin
      fm  = (tags.size() == 4);
      em  = (tags.size() == 0);
      wok = w && !fm;
      rok = r && !em;
      e_vwq = e_vw; e_avq = e_vw; e_aiq = !e_vw; e_asq = 1'b1;
      e_ovf = w && fm;
      e_unf = r && em;
      e_vw  = wok && d;
      if (rok) void'(tags.pop_front());
      if (wok) tags.push_back(d);
    end
    @(posedge clock);
    #1;
    sclr = 0; wrreq = 0; rdreq = 0; valid_data = 0;
    $display("t=%0t s=%0b w=%0b r=%0b d=%0b -> usedw=%0d empty=%0b full=%0b q=%0b ovf=%0b unf=%0b vw=%0b",
             $time, s, w, r, d, usedw_o, empty_o, full_o, q_o, ovf_o, unf_o, vw_o);
    chk("empty", {3'b0, empty_o}, {3'b0, tags.size() == 0});
    chk("full", {3'b0, full_o}, {3'b0, tags.size() == 4});
    chk("almost_full", {3'b0, afull_o}, {3'b0, tags.size() >= 3});
    chk("usedw", {2'b0, usedw_o}, 4'(tags.size() % 4));
    chk("q", {3'b0, q_o}, {3'b0, (tags.size() != 0) ? tags[0] : 1'b0});
    chk("overflow", {3'b0, ovf_o}, {3'b0, e_ovf});
    chk("underflow", {3'b0, unf_o}, {3'b0, e_unf});
    chk("valid_w", {3'b0, vw_o}, {3'b0, e_vw});
    chk("av_w", {3'b0, av_o}, {3'b0, e_vw});
    chk("ai_w", {3'b0, ai_o}, {3'b0, !e_vw});
    chk("assign_w", {3'b0, as_o}, 4'd1);
    chk("valid_w_q", {3'b0, vwq_o}, {3'b0, e_vwq});
    chk("av_w_q", {3'b0, avq_o}, {3'b0, e_avq});
    chk("ai_w_q", {3'b0, aiq_o}, {3'b0, e_aiq});
    chk("assign_w_q", {3'b0, asq_o}, {3'b0, e_asq});
  endtask

  initial begin
    bit d;
    // Reset, then idle: delayed ai/assign copies rise one cycle later.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // Fill with 1,0,1,0; then a rejected write pulses overflow once.
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    // Drain to 2, then simultaneous write+read keeps occupancy at 2.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    // Empty: lone read underflows; write+read accepts only the write.
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0);
    // Fill to full and do write+read: read accepted, write rejected.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    // At usedw=3, clear with a concurrent write; old tags must vanish.
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    cyc(0, 0, 0, 0);
    // Write/read pairs across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      d = 1'($urandom_range(0, 1));
      cyc(1, 0, d, 0);
      cyc(0, 1, 0, 0);
    end
    // Mixed: keep two in flight with simultaneous traffic.
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      d = 1'($urandom_range(0, 1));
      cyc(1, 1, d, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
